note_detector: RTL and testbench
================================

# note_detector

Reads the spectrum magnitude memory written by the FFT/magnitude stage and decides which recorder note is sounding. On each `start` pulse it scans a fixed list of note bins, finds the loudest one above a threshold, and debounces the result across consecutive scans. Its registered note code drives the game scoring and video display logic.

## Interface
- `NUM_NOTES`, 60: entries in the note-bin table. Note codes are 0..NUM_NOTES-1.
- `THRESH`, 10'd64: minimum magnitude for a note to count as present.
- `STABLE_SCANS`, 3: consecutive identical scan results required before `note` changes. Range 1..15.
- `clock_27mhz`  in  1: system clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: one-cycle pulse requesting a scan, issued after a full spectrum frame has been written.
- `raddr`  out  12: read address to the spectrum memory read port.
- `rdata`  in  10: magnitude from the spectrum memory; valid exactly 1 cycle after `raddr`.
- `busy`  out  1: high while a scan is in progress.
- `scan_done`  out  1: one-cycle pulse when a scan completes.
- `note`  out  6: debounced note code; 6'h3F = silence.
- `note_mag`  out  10: magnitude of the debounced note; 0 when silent.
- `note_changed`  out  1: one-cycle pulse, coincident with `scan_done`, when `note` takes a new value.

## Operation
- Reset values:
  - `raddr`=0, `busy`=0, `scan_done`=0, `note_changed`=0.
  - `note`=6'h3F, `note_mag`=0.
  - Internal state: `cand_prev`=6'h3F, `stable_cnt`=0, `pending`=0.
- FSM states: IDLE, SCAN, LAST, DECIDE.
- **IDLE**
  - On `start` or `pending`: clear `pending`, set `idx`=0, `best_mag`=0, `best_idx`=6'h3F, go to SCAN.
- **SCAN**
  - Each cycle: `raddr` <= bin(`idx`), `idx` increments.
  - From the second SCAN cycle on, compare `rdata` (which belongs to index `idx`-1) against `best_mag`.
  - After issuing index NUM_NOTES-1, go to LAST.
- **LAST**
  - Compare the final `rdata`, then go to DECIDE.
- **Compare rule**
  - Update the running best only if `rdata` > `best_mag` (strictly greater).
  - On ties the lower note index wins.
- **DECIDE**
  - Candidate = `best_idx` if `best_mag` >= THRESH, else 6'h3F.
  - If candidate == `cand_prev`, `stable_cnt` increments, saturating at 15. Otherwise `stable_cnt`=1 and `cand_prev`=candidate.
  - When `stable_cnt` (after update) >= STABLE_SCANS and candidate != `note`:
    - `note` <= candidate.
    - `note_mag` <= `best_mag`, or 0 if candidate is silence.
    - Pulse `note_changed`.
  - When candidate == `note`, `note_mag` refreshes to the current magnitude (0 if silent) with no `note_changed` pulse.
  - Always pulse `scan_done`, then return to IDLE.
- **`start` while not IDLE:** sets `pending`. Multiple such starts collapse to one rescan. A rescan begins the cycle after DECIDE.
- **`busy`:** high in SCAN, LAST and DECIDE.
- **Reset mid-scan:** abort immediately to the reset values. No `scan_done` is produced.

## Timing
- Start accepted at rising edge E0.
- `raddr` = bin(k) during cycles E0+1+k, for k = 0..N-1.
- `rdata` for bin(k) is sampled at edge E0+2+k.
- DECIDE at edge E0+N+2.
- `scan_done`, `note_changed` and the updated `note`/`note_mag` are visible from E0+N+2 to E0+N+3.
- Scan latency: N+2 cycles (62 for N=60).
- Back-to-back throughput: one scan per N+3 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `note_pkg`:
  - `NOTE_SILENT` = 6'h3F.
  - Widths: `HADDR_W`=12, `HDATA_W`=10, `NOTE_W`=6.
  - State encoding.
  - Constant array of 60 bin addresses, in note order from the low recorder note upward.
- Sub-module `note_bin_rom`: combinational lookup from `idx` to 12-bit bin address, backed by the package array.

## Test plan
- **Single tone.** Memory is all 0 except bin(5)=200. Three `start` pulses spaced 100 cycles apart. Scans 1–2 give `note`=3F. Scan 3 gives `note`=5, `note_mag`=200, `note_changed`=1 exactly 62 cycles after the start.
- **Below threshold.** bin(5)=63, all others 0. Ten scans: `note` stays 3F, `note_changed` never pulses, `scan_done` pulses 10 times.
- **Tie.** bin(7)=bin(20)=150, three scans: `note`=7.
- **Debounce.** Spectrum alternates between bin(3)=300 and bin(9)=300 on every scan: `note` never leaves 3F. Then bin(9) is held for 3 scans: `note`=9.
- **Overlap.** `start` pulsed at cycles 0, 10 and 20: exactly two `scan_done` pulses, at cycles 62 and 125. `raddr` sequence matches the ROM each time.
- **Reset mid-scan.** `reset_n` low at cycle 30 of a scan: all outputs return to their reset values. No `scan_done`. The next `start` runs a full 62-cycle scan.

Source files
------------

// File: rtl/note_pkg.sv
// -----------------------------------------------------------------------------
// note_pkg
// Shared types and constants for the recorder note detector:
//   - spectrum memory address/data widths and note code width
//   - NOTE_SILENT, the note code reported when nothing is loud enough
//   - scan FSM state encoding
//   - BIN_ADDR: spectrum bin address of each note, lowest recorder note first
// -----------------------------------------------------------------------------
package note_pkg;

    localparam int HADDR_W  = 12;
    localparam int HDATA_W  = 10;
    localparam int NOTE_W   = 6;
    localparam int NUM_BINS = 60;

    localparam logic [NOTE_W-1:0] NOTE_SILENT = 6'h3F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_LAST,
        ST_DECIDE
    } state_e;

    // Roughly one semitone apart; the spacing widens with frequency.
    localparam logic [HADDR_W-1:0] BIN_ADDR [NUM_BINS] = '{
        12'd48,   12'd51,   12'd54,   12'd57,   12'd60,
        12'd64,   12'd68,   12'd72,   12'd76,   12'd81,
        12'd86,   12'd91,   12'd96,   12'd102,  12'd108,
        12'd114,  12'd121,  12'd128,  12'd136,  12'd144,
        12'd153,  12'd162,  12'd172,  12'd182,  12'd193,
        12'd204,  12'd216,  12'd229,  12'd243,  12'd257,
        12'd273,  12'd289,  12'd306,  12'd324,  12'd344,
        12'd364,  12'd386,  12'd409,  12'd433,  12'd459,
        12'd486,  12'd515,  12'd546,  12'd578,  12'd613,
        12'd649,  12'd688,  12'd729,  12'd772,  12'd818,
        12'd867,  12'd918,  12'd973,  12'd1031, 12'd1092,
        12'd1157, 12'd1226, 12'd1299, 12'd1376, 12'd1458
    };

endpackage

// File: rtl/note_bin_rom.sv
// -----------------------------------------------------------------------------
// note_bin_rom
// Combinational lookup from note index to spectrum bin address.
//   idx_i  : note index 0..NUM_BINS-1
//   addr_o : bin address of that note (0 for indices past the table)
// -----------------------------------------------------------------------------
module note_bin_rom
    import note_pkg::*;
(
    input  logic [NOTE_W-1:0]  idx_i,
    output logic [HADDR_W-1:0] addr_o
);

    always_comb begin
        addr_o = '0;
        if (idx_i < NOTE_W'(NUM_BINS)) begin
            addr_o = BIN_ADDR[idx_i];
        end
    end

endmodule

// File: rtl/note_detector.sv
// -----------------------------------------------------------------------------
// note_detector
// On each start pulse, walks the note-bin table through the spectrum memory,
// keeps the loudest bin (lowest index on ties), and debounces the winner over
// consecutive scans before reporting it as the current note.
//   clock_27mhz  : system clock
//   reset_n      : asynchronous active-low reset
//   start        : scan request pulse; requests during a scan queue one rescan
//   raddr/rdata  : spectrum memory read port (rdata belongs to last cycle's raddr)
//   busy         : scan in progress
//   scan_done    : one-cycle pulse at the end of every scan
//   note         : debounced note code, NOTE_SILENT when nothing is sounding
//   note_mag     : magnitude of the reported note, 0 when silent
//   note_changed : one-cycle pulse with scan_done when note takes a new value
// -----------------------------------------------------------------------------
module note_detector
    import note_pkg::*;
#(
    parameter int                 NUM_NOTES    = 60,
    parameter logic [HDATA_W-1:0] THRESH       = 10'd64,
    parameter int                 STABLE_SCANS = 3
) (
    input  logic               clock_27mhz,
    input  logic               reset_n,
    input  logic               start,
    output logic [HADDR_W-1:0] raddr,
    input  logic [HDATA_W-1:0] rdata,
    output logic               busy,
    output logic               scan_done,
    output logic [NOTE_W-1:0]  note,
    output logic [HDATA_W-1:0] note_mag,
    output logic               note_changed
);

    localparam logic [NOTE_W-1:0] LAST_IDX   = NOTE_W'(NUM_NOTES - 1);
    localparam logic [3:0]        STABLE_LIM = 4'(STABLE_SCANS);

    state_e              state_q,        state_d;
    logic [NOTE_W-1:0]   idx_q,          idx_d;
    logic [HDATA_W-1:0]  best_mag_q,     best_mag_d;
    logic [NOTE_W-1:0]   best_idx_q,     best_idx_d;
    logic [NOTE_W-1:0]   cand_prev_q,    cand_prev_d;
    logic [3:0]          stable_cnt_q,   stable_cnt_d;
    logic                pending_q,      pending_d;
    logic [HADDR_W-1:0]  raddr_q,        raddr_d;
    logic                scan_done_q,    scan_done_d;
    logic                note_changed_q, note_changed_d;
    logic [NOTE_W-1:0]   note_q,         note_d;
    logic [HDATA_W-1:0]  note_mag_q,     note_mag_d;

    logic [HADDR_W-1:0]  bin_addr;
    logic [NOTE_W-1:0]   rdata_idx;
    logic                take_rdata;
    logic [NOTE_W-1:0]   cand;
    logic [HDATA_W-1:0]  cand_mag;

    note_bin_rom u_rom (
        .idx_i  (idx_q),
        .addr_o (bin_addr)
    );

    // rdata lags raddr by one cycle: in SCAN it belongs to idx-1, in LAST to
    // the final table entry. The first SCAN cycle has no data yet.
    assign rdata_idx  = (state_q == ST_LAST) ? LAST_IDX : idx_q - NOTE_W'(1);
    assign take_rdata = ((state_q == ST_SCAN && idx_q != '0) || state_q == ST_LAST)
                        && (rdata > best_mag_q);

    assign cand     = (best_mag_q >= THRESH) ? best_idx_q : NOTE_SILENT;
    assign cand_mag = (cand == NOTE_SILENT) ? '0 : best_mag_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through
        // the case statement leaves one unassigned, which would infer a latch.
        state_d        = state_q;
        idx_d          = idx_q;
        best_mag_d     = best_mag_q;
        best_idx_d     = best_idx_q;
        cand_prev_d    = cand_prev_q;
        stable_cnt_d   = stable_cnt_q;
        pending_d      = pending_q;
        raddr_d        = raddr_q;
        scan_done_d    = 1'b0;
        note_changed_d = 1'b0;
        note_d         = note_q;
        note_mag_d     = note_mag_q;

        if (take_rdata) begin
            best_mag_d = rdata;
            best_idx_d = rdata_idx;
        end

        // Any number of starts during a scan collapse into one rescan.
        if (start && state_q != ST_IDLE) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start || pending_q) begin
                    pending_d  = 1'b0;
                    idx_d      = '0;
                    best_mag_d = '0;
                    best_idx_d = NOTE_SILENT;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                raddr_d = bin_addr;
                idx_d   = idx_q + NOTE_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = ST_LAST;
                end
            end
            ST_LAST: begin
                state_d = ST_DECIDE;
            end
            ST_DECIDE: begin
                if (cand == cand_prev_q) begin
                    if (stable_cnt_q != 4'hF) begin
                        stable_cnt_d = stable_cnt_q + 4'd1;
                    end
                end else begin
                    stable_cnt_d = 4'd1;
                    cand_prev_d  = cand;
                end

                if (stable_cnt_d >= STABLE_LIM && cand != note_q) begin
                    note_d         = cand;
                    note_mag_d     = cand_mag;
                    note_changed_d = 1'b1;
                end else if (cand == note_q) begin
                    note_mag_d = cand_mag;
                end

                scan_done_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_27mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            best_mag_q     <= '0;
            best_idx_q     <= NOTE_SILENT;
            cand_prev_q    <= NOTE_SILENT;
            stable_cnt_q   <= '0;
            pending_q      <= 1'b0;
            raddr_q        <= '0;
            scan_done_q    <= 1'b0;
            note_changed_q <= 1'b0;
            note_q         <= NOTE_SILENT;
            note_mag_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values from before this edge, independent of statement order.
            state_q        <= state_d;
            idx_q          <= idx_d;
            best_mag_q     <= best_mag_d;
            best_idx_q     <= best_idx_d;
            cand_prev_q    <= cand_prev_d;
            stable_cnt_q   <= stable_cnt_d;
            pending_q      <= pending_d;
            raddr_q        <= raddr_d;
            scan_done_q    <= scan_done_d;
            note_changed_q <= note_changed_d;
            note_q         <= note_d;
            note_mag_q     <= note_mag_d;
        end
    end

    assign raddr        = raddr_q;
    assign busy         = (state_q != ST_IDLE);
    assign scan_done    = scan_done_q;
    assign note_changed = note_changed_q;
    assign note         = note_q;
    assign note_mag     = note_mag_q;

endmodule

// File: tb/tb_note_detector.sv
// -----------------------------------------------------------------------------
// tb_note_detector
// Drives note_detector against a spectrum memory held in the bench. A reference
// model predicts every output each cycle from scan timing arithmetic and an
// argmax/debounce-history view of the spectrum; directed scenarios add literal
// expectations for latency, table endpoints and final note codes.
// -----------------------------------------------------------------------------
module tb_note_detector;
    import note_pkg::*;

    localparam int N      = 60;
    localparam int THR    = 64;
    localparam int STABLE = 3;

    logic               clock_27mhz = 1'b0;
    logic               reset_n     = 1'b0;
    logic               start       = 1'b0;
    logic [HADDR_W-1:0] raddr;
    logic [HDATA_W-1:0] rdata;
    logic               busy;
    logic               scan_done;
    logic [NOTE_W-1:0]  note;
    logic [HDATA_W-1:0] note_mag;
    logic               note_changed;

    logic [HDATA_W-1:0] mem [4096];
    assign rdata = mem[raddr];

    int checks        = 0;
    int errors        = 0;
    int done_count    = 0;
    int changed_count = 0;
    int edge_cnt      = 0;

    // reference model state
    logic               m_scanning  = 1'b0;
    logic               m_pending   = 1'b0;
    int                 m_e0        = 0;
    int                 m_off       = 0;
    logic [NOTE_W-1:0]  exp_note    = NOTE_SILENT;
    logic [HDATA_W-1:0] exp_mag     = '0;
    logic               exp_done    = 1'b0;
    logic               exp_changed = 1'b0;
    logic [HADDR_W-1:0] exp_raddr   = '0;
    logic [NOTE_W-1:0]  hist [$];

    note_detector #(
        .NUM_NOTES    (N),
        .THRESH       (10'(THR)),
        .STABLE_SCANS (STABLE)
    ) dut (
        .clock_27mhz  (clock_27mhz),
        .reset_n      (reset_n),
        .start        (start),
        .raddr        (raddr),
        .rdata        (rdata),
        .busy         (busy),
        .scan_done    (scan_done),
        .note         (note),
        .note_mag     (note_mag),
        .note_changed (note_changed)
    );

    always #5 clock_27mhz = ~clock_27mhz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Loudest bin wins (first one on ties); the note only moves once the last
    // STABLE scan winners all agree and differ from what is reported.
    task automatic model_decide();
        logic [HDATA_W-1:0] bm;
        logic [NOTE_W-1:0]  bi;
        logic [NOTE_W-1:0]  cand;
        logic               stable;
        bm = '0;
        bi = NOTE_SILENT;
        for (int k = 0; k < N; k++) begin
            if (mem[BIN_ADDR[k]] > bm) begin
                bm = mem[BIN_ADDR[k]];
                bi = NOTE_W'(k);
            end
        end
        cand = (int'(bm) >= THR) ? bi : NOTE_SILENT;
        hist.push_back(cand);
        if (hist.size() > STABLE) void'(hist.pop_front());
        stable = (hist.size() == STABLE);
        foreach (hist[i]) if (hist[i] != cand) stable = 1'b0;
        if (stable && cand != exp_note) begin
            exp_note    = cand;
            exp_mag     = (cand == NOTE_SILENT) ? '0 : bm;
            exp_changed = 1'b1;
        end else if (cand == exp_note) begin
            exp_mag = (cand == NOTE_SILENT) ? '0 : bm;
        end
    endtask

    // Model: a scan accepted at edge E0 issues bin(k) at edge E0+1+k and
    // reports at edge E0+N+2; starts seen while scanning leave one rescan.
    initial forever begin
        @(posedge clock_27mhz or negedge reset_n);
        if (!reset_n) begin
            m_scanning  = 1'b0;
            m_pending   = 1'b0;
            exp_note    = NOTE_SILENT;
            exp_mag     = '0;
            exp_done    = 1'b0;
            exp_changed = 1'b0;
            exp_raddr   = '0;
            hist.delete();
        end else begin
            edge_cnt++;
            exp_done    = 1'b0;
            exp_changed = 1'b0;
            if (m_scanning) begin
                m_off = edge_cnt - m_e0;
                if (start) m_pending = 1'b1;
                if (m_off >= 1 && m_off <= N) exp_raddr = BIN_ADDR[m_off-1];
                if (m_off == N + 2) begin
                    model_decide();
                    exp_done   = 1'b1;
                    m_scanning = 1'b0;
                end
            end else if (start || m_pending) begin
                m_scanning = 1'b1;
                m_pending  = 1'b0;
                m_e0       = edge_cnt;
            end
        end
    end

    // Compare every output against the model, away from the active edge.
    initial forever begin
        @(negedge clock_27mhz);
        check("busy",         32'(busy),         32'(m_scanning));
        check("scan_done",    32'(scan_done),    32'(exp_done));
        check("note_changed", 32'(note_changed), 32'(exp_changed));
        check("note",         32'(note),         32'(exp_note));
        check("note_mag",     32'(note_mag),     32'(exp_mag));
        check("raddr",        32'(raddr),        32'(exp_raddr));
        if (scan_done === 1'b1)    done_count++;
        if (note_changed === 1'b1) changed_count++;
    end

    // All stimulus tasks start and end 2 time units after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clock_27mhz);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(2);
    endtask

    task automatic clear_bins();
        for (int k = 0; k < N; k++) mem[BIN_ADDR[k]] = '0;
    endtask

    task automatic run_scan();
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(70);
    endtask

    // Issue one start and return the cycles from acceptance to scan_done,
    // left positioned inside the scan_done cycle (100 if it never came).
    task automatic timed_scan(output int lat);
        logic got;
        got   = 1'b0;
        lat   = 0;
        start = 1'b1;
        @(posedge clock_27mhz);
        #2;
        start = 1'b0;
        while (lat < 100 && !got) begin
            @(posedge clock_27mhz);
            lat++;
            #1;
            if (lat == 1)  check("bin0_addr",  32'(raddr), 32'd48);
            if (lat == 60) check("bin59_addr", 32'(raddr), 32'd1458);
            if (scan_done === 1'b1) got = 1'b1;
            #1;
        end
    endtask

    initial begin
        int lat;
        int d0;
        int c0;
        int pk;
        logic [31:0] done_at [$];

        for (int a = 0; a < 4096; a++) mem[a] = '0;
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(2);
        check("reset_note", 32'(note), 32'h3F);
        check("reset_busy", 32'(busy), 32'd0);

        // single tone
        clear_bins();
        mem[BIN_ADDR[5]] = 10'd200;
        for (int s = 0; s < 3; s++) begin
            timed_scan(lat);
            check("tone_latency", 32'(lat), 32'd62);
            check("tone_note", 32'(note), (s == 2) ? 32'd5 : 32'h3F);
            check("tone_changed", 32'(note_changed), (s == 2) ? 32'd1 : 32'd0);
            if (s == 2) check("tone_mag", 32'(note_mag), 32'd200);
            tick(38);
        end

        // below threshold
        do_reset();
        clear_bins();
        mem[BIN_ADDR[5]] = 10'd63;
        d0 = done_count;
        c0 = changed_count;
        for (int s = 0; s < 10; s++) run_scan();
        check("thr_done_count", 32'(done_count - d0), 32'd10);
        check("thr_changed_count", 32'(changed_count - c0), 32'd0);
        check("thr_note", 32'(note), 32'h3F);

        // tie: lower index wins
        do_reset();
        clear_bins();
        mem[BIN_ADDR[7]]  = 10'd150;
        mem[BIN_ADDR[20]] = 10'd150;
        for (int s = 0; s < 3; s++) run_scan();
        check("tie_note", 32'(note), 32'd7);
        check("tie_mag", 32'(note_mag), 32'd150);

        // debounce: alternating winners never settle
        do_reset();
        for (int s = 0; s < 6; s++) begin
            clear_bins();
            mem[BIN_ADDR[(s % 2 == 0) ? 9 : 3]] = 10'd300;
            run_scan();
            check("alt_note", 32'(note), 32'h3F);
        end
        clear_bins();
        mem[BIN_ADDR[9]] = 10'd300;
        for (int s = 0; s < 3; s++) begin
            run_scan();
            check("hold_note", 32'(note), (s == 2) ? 32'd9 : 32'h3F);
        end

        // overlapping starts at cycles 0, 10, 20
        do_reset();
        for (int k = 0; k < N; k++) mem[BIN_ADDR[k]] = 10'($urandom_range(0, 500));
        start = 1'b1;
        @(posedge clock_27mhz);
        #2;
        start = 1'b0;
        lat   = 0;
        while (lat < 200) begin
            @(posedge clock_27mhz);
            lat++;
            #1;
            if (scan_done === 1'b1) done_at.push_back(32'(lat));
            #1;
            start = (lat == 9 || lat == 19);
        end
        check("ovl_done_count", 32'(done_at.size()), 32'd2);
        if (done_at.size() == 2) begin
            check("ovl_done_1", done_at[0], 32'd62);
            check("ovl_done_2", done_at[1], 32'd125);
        end

        // reset in the middle of a scan
        clear_bins();
        mem[BIN_ADDR[40]] = 10'd500;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(29);
        reset_n = 1'b0;
        #1;
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_raddr", 32'(raddr),     32'd0);
        check("rst_note",  32'(note),      32'h3F);
        check("rst_done",  32'(scan_done), 32'd0);
        tick(3);
        reset_n = 1'b1;
        d0 = done_count;
        tick(80);
        check("rst_no_done", 32'(done_count - d0), 32'd0);
        timed_scan(lat);
        check("rst_rescan_latency", 32'(lat), 32'd62);
        tick(10);

        // randomized spectra with occasional mid-scan starts
        for (int s = 0; s < 40; s++) begin
            pk = 4 + 20 * int'($urandom_range(0, 2));
            for (int k = 0; k < N; k++) mem[BIN_ADDR[k]] = 10'($urandom_range(0, 70));
            mem[BIN_ADDR[pk]] = 10'($urandom_range(40, 400));
            if ($urandom_range(0, 3) == 0) mem[BIN_ADDR[$urandom_range(0, N-1)]] = mem[BIN_ADDR[pk]];
            start = 1'b1;
            tick(1);
            start = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                tick(int'($urandom_range(5, 55)));
                start = 1'b1;
                tick(1);
                start = 1'b0;
                tick(140);
            end else begin
                tick(70);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
